// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Purpose:
//   Multi-cycle execute-stage sequencer wrapped around an external 16-bit
//   two's-complement adder/subtractor. It collects operand A and then operand
//   B from a shared operand bus and drives the adder inputs. It captures the
//   adder sum and carry into ALU_OUT and the Z/N/C/V flags, then pulses
//   DONE (and RF_WE for result-producing ops) towards the main control FSM.
//
//   Sequence: IDLE -> GET_A -> GET_B -> EXEC -> WB -> IDLE
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   START, OP        start request and opcode, sampled only in IDLE
//                    (00 ADD, 01 SUB, 10 CMP, 11 PASS)
//   OPND, OPND_VALID shared operand bus and its valid qualifier
//   ADD_A/B/CTRL     drive to the adder (CTRL=1 selects subtract)
//   ADD_S, ADD_COUT  sum and carry returned by the adder
//   ALU_OUT          registered result
//   FLAG_Z/N/C/V     registered flags (C=1 means no borrow for SUB/CMP)
//   BUSY             high in every state except IDLE
//   DONE, RF_WE      one-cycle completion pulse / register-file write strobe
//   DBG_STATE        current FSM state, for observation only
//
// Operand handshake: OPND_VALID is a valid-only qualifier with no ready back.
// An operand is consumed on any rising edge where OPND_VALID=1 while the FSM
// sits in GET_A (operand A) or GET_B (operand B). Outside those states the
// bus is ignored. The producer keeps OPND_VALID low to stall, for as long as
// it needs.
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] OPND,
  input  logic             OPND_VALID,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  output logic             ADD_CTRL,
  input  logic [WIDTH-1:0] ADD_S,
  input  logic             ADD_COUT,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             FLAG_Z,
  output logic             FLAG_N,
  output logic             FLAG_C,
  output logic             FLAG_V,
  output logic             BUSY,
  output logic             DONE,
  output logic             RF_WE,
  output logic [2:0]       DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_busy;
  logic             r_done;
  logic             r_rf_we;

  logic             w_is_sub;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_s_msb;
  logic             w_v_add;
  logic             w_v_sub;
  logic             w_v;

  // The adder is driven straight from the operand/opcode registers. They only
  // change in IDLE/GET_A/GET_B, so A, B and CTRL are stable through EXEC and WB.
  assign w_is_sub = (r_op == OP_SUB) || (r_op == OP_CMP);
  assign ADD_A    = r_a;
  assign ADD_B    = (r_op == OP_PASS) ? '0 : r_b;
  assign ADD_CTRL = w_is_sub;

  // Overflow is judged on the true operands (B register, not the
  // possibly-inverted adder input). Adding like signs or subtracting unlike
  // signs overflows when the result sign differs from A.
  assign w_a_msb = r_a[WIDTH-1];
  assign w_b_msb = r_b[WIDTH-1];
  assign w_s_msb = ADD_S[WIDTH-1];
  assign w_v_add = (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
  assign w_v_sub = (w_a_msb != w_b_msb) && (w_s_msb != w_a_msb);

  always_comb begin
    w_v = 1'b0;
    case (r_op)
      OP_ADD:          w_v = w_v_add;
      OP_SUB, OP_CMP:  w_v = w_v_sub;
      default:         w_v = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rf_we   <= 1'b0;
    end else begin
      // DONE and RF_WE are single-cycle pulses; they are set only on EXEC exit.
      r_done  <= 1'b0;
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_op    <= OP;
            r_busy  <= 1'b1;
            r_state <= S_GET_A;
          end
        end
        S_GET_A: begin
          if (OPND_VALID) begin
            r_a     <= OPND;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (OPND_VALID) begin
            r_b     <= OPND;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // CMP only updates flags; the previous result stays visible.
          if (r_op != OP_CMP) begin
            r_alu_out <= ADD_S;
          end
          r_z     <= (ADD_S == '0);
          r_n     <= w_s_msb;
          r_c     <= (r_op == OP_PASS) ? 1'b0 : ADD_COUT;
          r_v     <= w_v;
          r_done  <= 1'b1;
          r_rf_we <= (r_op != OP_CMP);
          r_state <= S_WB;
        end
        S_WB: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ALU_OUT   = r_alu_out;
  assign FLAG_Z    = r_z;
  assign FLAG_N    = r_n;
  assign FLAG_C    = r_c;
  assign FLAG_V    = r_v;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign RF_WE     = r_rf_we;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//
// Drives alu_exec_ctrl together with a behavioural model of the external
// 16-bit adder/subtractor. Results are predicted by an arithmetic reference
// model (integer add/subtract, range checks for overflow). They are queued
// at issue and compared when DONE pulses.
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  localparam int WIDTH = 16;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // ---------------------------------------------------------------- clock/reset
  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opnd;
  logic             opnd_valid;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_ctrl;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic [WIDTH-1:0] alu_out;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic             busy, done, rf_we;
  logic [2:0]       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: A + B, or A + ~B + 1 when subtracting.
  logic [WIDTH:0] adder_sum;
  assign adder_sum = {1'b0, add_a} + {1'b0, (add_ctrl ? ~add_b : add_b)} + {{WIDTH{1'b0}}, add_ctrl};
  assign add_s     = adder_sum[WIDTH-1:0];
  assign add_cout  = adder_sum[WIDTH];

  alu_exec_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op), .OPND(opnd),
    .OPND_VALID(opnd_valid), .ADD_A(add_a), .ADD_B(add_b),
    .ADD_CTRL(add_ctrl), .ADD_S(add_s), .ADD_COUT(add_cout),
    .ALU_OUT(alu_out), .FLAG_Z(flag_z), .FLAG_N(flag_n), .FLAG_C(flag_c),
    .FLAG_V(flag_v), .BUSY(busy), .DONE(done), .RF_WE(rf_we),
    .DBG_STATE(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];       // {alu_out, z, n, c, v}
  logic [15:0] m_alu = 16'h0;  // model's view of the ALU_OUT register

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [19:0] model(input logic [1:0] m_op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] prev);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] res, out;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    res = 16'h0; out = prev; c = 1'b0; v = 1'b0;
    case (m_op)
      OP_ADD: begin
        ur = ua + ub; sr = sa + sb;
        res = ur[15:0]; c = (ur > 65535); v = (sr > 32767) || (sr < -32768); out = res;
      end
      OP_SUB, OP_CMP: begin
        ur = ua - ub; sr = sa - sb;
        res = ur[15:0]; c = (ua >= ub); v = (sr > 32767) || (sr < -32768);
        out = (m_op == OP_CMP) ? prev : res;
      end
      default: begin
        res = a; c = 1'b0; v = 1'b0; out = a;
      end
    endcase
    return {out, (res == 16'h0), res[15], c, v};
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic noise();
    start = 1'($urandom_range(0, 1));
    op    = 2'($urandom_range(0, 3));
  endtask

  // Issues one operation starting in the current (IDLE) negedge, with the
  // given number of stall cycles before each operand, and checks it end to end.
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int st_a, input int st_b);
    int cyc;
    int guard;
    logic [19:0] e;
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    check({name, "_idle"}, busy, 0);
    exp_q.push_back(model(o, a, b, m_alu));
    cyc = 0;
    start = 1'b1; op = o; opnd_valid = 1'b0;
    repeat (st_a) begin
      @(negedge clk); cyc++; noise(); opnd_valid = 1'b0; opnd = 16'($urandom);
    end
    @(negedge clk); cyc++; noise(); opnd_valid = 1'b1; opnd = a;
    repeat (st_b) begin
      @(negedge clk); cyc++; noise(); opnd_valid = 1'b0; opnd = 16'($urandom);
    end
    @(negedge clk); cyc++; noise(); opnd_valid = 1'b1; opnd = b;
    // EXEC cycle: adder drive must reflect the operation issued at START.
    @(negedge clk); cyc++; noise(); opnd_valid = 1'b0; opnd = 16'($urandom);
    check({name, "_add_a"}, add_a, a);
    check({name, "_add_b"}, add_b, (o == OP_PASS) ? 16'h0 : b);
    check({name, "_ctrl"}, add_ctrl, (o == OP_SUB || o == OP_CMP));
    check({name, "_busy"}, busy, 1);
    check({name, "_early_done"}, done, 0);
    guard = 0;
    do begin
      @(negedge clk); cyc++; guard++; noise();
    end while (!done && guard < 20);
    start = 1'b0;
    check({name, "_done_seen"}, done, 1);
    check({name, "_latency"}, cyc, 4 + st_a + st_b);
    check({name, "_rf_we"}, rf_we, (o != OP_CMP));
    e = exp_q.pop_front();
    m_alu = e[19:4];
    check({name, "_alu_out"}, alu_out, e[19:4]);
    check({name, "_flags_zncv"}, {flag_z, flag_n, flag_c, flag_v}, e[3:0]);
    // Next cycle is IDLE again: pulses gone, ready to accept START.
    @(negedge clk);
    check({name, "_done_pulse"}, {done, rf_we}, 2'b00);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_hold"}, {alu_out, flag_z, flag_n, flag_c, flag_v}, e);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners[6];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; opnd = 16'h0; opnd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {alu_out, flag_z, flag_n, flag_c, flag_v, busy, done, rf_we}, 0);
    check("rst_adder", {add_a, add_b, add_ctrl}, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_5_3",      OP_ADD,  16'h0005, 16'h0003, 0, 0);
    run_op("sub_3_8",      OP_SUB,  16'h0003, 16'h0008, 0, 0);
    run_op("add_neg",      OP_ADD,  16'hFFF6, 16'hFFF1, 0, 0);
    run_op("add_ovf",      OP_ADD,  16'h7FFF, 16'h0001, 0, 0);
    run_op("sub_ovf",      OP_SUB,  16'h8000, 16'h0001, 0, 0);
    run_op("add_1234",     OP_ADD,  16'h1230, 16'h0004, 0, 0);
    run_op("cmp_eq",       OP_CMP,  16'h0005, 16'h0005, 0, 0);
    check("cmp_keeps_alu", alu_out, 16'h1234);
    run_op("pass",         OP_PASS, 16'hABCD, 16'h9999, 0, 0);
    run_op("stall_3_2",    OP_SUB,  16'h1000, 16'h0FFF, 3, 2);
    run_op("add_wrap",     OP_ADD,  16'hFFFF, 16'h0001, 1, 0);

    // Abort in GET_B with an asynchronous reset.
    start = 1'b1; op = OP_SUB;
    @(negedge clk); start = 1'b0; opnd_valid = 1'b1; opnd = 16'h5555;
    @(negedge clk); opnd_valid = 1'b0;
    check("abort_in_get_b", dbg_state, 2);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", {alu_out, flag_z, flag_n, flag_c, flag_v, busy, done, rf_we}, 0);
    check("abort_adder", {add_a, add_b, add_ctrl}, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", {done, rf_we}, 2'b00);
    end
    rst = 1'b0;
    m_alu = 16'h0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done_after", {done, rf_we, busy}, 3'b000);
    end
    run_op("post_rst_add", OP_ADD, 16'h0001, 16'h0001, 0, 0);

    // Randomized back-to-back operations with random stalls.
    for (int i = 0; i < 40; i++) begin
      run_op("rnd", 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute-stage sequencer that sits directly upstream and downstream of the 16-bit two's-complement adder/subtractor FA_2s_16bits. It collects two operands from the shared operand bus over successive cycles and drives the adder's A, B and CTRL inputs. It then captures S and C_out into the ALUOut register and the flag register, and signals completion to the main control FSM with a write-back strobe.

Parameters:
WIDTH, 16, datapath width. Must match the adder.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  begin operation; sampled only in IDLE
OP  input  2  00 ADD, 01 SUB, 10 CMP (subtract, flags only), 11 PASS (result = A)
OPND  input  WIDTH  shared operand bus
OPND_VALID  input  1  OPND carries the next operand this cycle
ADD_A  output  WIDTH  to adder A
ADD_B  output  WIDTH  to adder B
ADD_CTRL  output  1  to adder CTRL (1 = subtract)
ADD_S  input  WIDTH  from adder S
ADD_COUT  input  1  from adder C_out
ALU_OUT  output  WIDTH  registered result (ALUOut)
FLAG_Z  output  1  zero
FLAG_N  output  1  negative (result bit 15)
FLAG_C  output  1  carry; for SUB/CMP, 1 = no borrow
FLAG_V  output  1  signed overflow
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle completion pulse
RF_WE  output  1  register-file write strobe, coincident with DONE

Behaviour:
- Reset (asynchronous, RST=1): state forced to IDLE. ALU_OUT, the flags, the internal A, B and OP registers, ADD_A, ADD_B, ADD_CTRL, BUSY, DONE and RF_WE are all 0. Reset asserted mid-operation aborts the operation; no DONE or RF_WE is produced.
- States: IDLE -> GET_A -> GET_B -> EXEC -> WB -> IDLE.
- IDLE: if START=1, latch OP and go to GET_A. START in any other state is ignored.
- GET_A: hold until OPND_VALID=1, then latch OPND into A_reg and go to GET_B. Stalls are unbounded.
- GET_B: hold until OPND_VALID=1, then latch OPND into B_reg and go to EXEC.
- Adder drive (combinational from registers): ADD_A = A_reg.
  - ADD_B = B_reg, except ADD_B = 0 for PASS.
  - ADD_CTRL = 1 for SUB and CMP, otherwise 0.
  - All three hold stable from EXEC through WB.
- EXEC (1 cycle): on the closing edge, capture ADD_S and ADD_COUT.
  - ALU_OUT <= ADD_S for ADD, SUB and PASS. ALU_OUT is unchanged for CMP.
  - FLAG_Z <= (ADD_S == 0).
  - FLAG_N <= ADD_S[15].
  - FLAG_C <= ADD_COUT for ADD, SUB and CMP; FLAG_C <= 0 for PASS.
  - FLAG_V, ADD: (A[15]==B[15]) && (S[15]!=A[15]).
  - FLAG_V, SUB/CMP: (A[15]!=B[15]) && (S[15]!=A[15]).
  - FLAG_V, PASS: 0.
  - Go to WB.
- WB (1 cycle): DONE=1. RF_WE=1 unless OP=CMP. Go to IDLE.
- Latency: START to DONE is 4 cycles when OPND_VALID is high in both GET_A and GET_B. Each cycle without OPND_VALID adds one cycle.
- Back-to-back operation: START may be asserted in the IDLE cycle that follows WB, giving a 5-cycle minimum issue interval.
- ALU_OUT and the flags hold their values between operations.
- Arithmetic is modulo 2^16. The carry out of bit 15 is reported only through FLAG_C and is never widened into ALU_OUT.

Test Plan:
- ADD 0x0005, 0x0003 with no stalls -> ADD_CTRL=0; ALU_OUT=0x0008, Z=0 N=0 C=0 V=0; DONE and RF_WE both pulse exactly 4 cycles after START.
- SUB 0x0003, 0x0008 -> ADD_CTRL=1; ALU_OUT=0xFFFB, N=1 C=0 V=0 Z=0. ADD 0xFFF6, 0xFFF1 -> ALU_OUT=0xFFE7, C=1 N=1 V=0.
- Overflow: ADD 0x7FFF, 0x0001 -> ALU_OUT=0x8000, V=1 N=1 C=0. SUB 0x8000, 0x0001 -> ALU_OUT=0x7FFF, V=1 C=1.
- CMP 0x0005, 0x0005 with ALU_OUT previously 0x1234 -> Z=1 C=1, ALU_OUT stays 0x1234, DONE=1 with RF_WE=0. PASS 0xABCD, 0x9999 -> ADD_B=0, ALU_OUT=0xABCD, C=0 V=0.
- Stalls and ignored START: hold OPND_VALID low for 3 cycles in GET_A and 2 cycles in GET_B -> DONE arrives at cycle 9. START pulses while BUSY=1 are ignored, and OP changes after the START cycle do not affect the result.
- Reset mid-operation: assert RST asynchronously in GET_B -> all outputs go to 0 immediately, no DONE/RF_WE is produced, and the next ADD 0x0001, 0x0001 yields 0x0002.
